// File: rtl/sdram_cmd_scheduler_if.sv
// Request/command bundle between the host request logic, the command scheduler
// and the SDRAM pin driver.
interface sdram_cmd_scheduler_if #(
  parameter int ROW_W  = 13,
  parameter int COL_W  = 9,
  parameter int BANK_W = 2
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [BANK_W-1:0] req_bank;
  logic [ROW_W-1:0]  req_row;
  logic [COL_W-1:0]  req_col;
  logic [2:0]        cmd_o;
  logic [BANK_W-1:0] ba_o;
  logic [ROW_W-1:0]  addr_o;
  logic              ref_overrun;

  modport master (
    output req_valid, req_we, req_bank, req_row, req_col,
    input  req_ready, cmd_o, ba_o, addr_o, ref_overrun
  );

  modport slave (
    input  req_valid, req_we, req_bank, req_row, req_col,
    output req_ready, cmd_o, ba_o, addr_o, ref_overrun
  );
endinterface

// File: rtl/sdram_cmd_scheduler.sv
// SDRAM command scheduler: ACT -> RD/WR (auto-precharge) and periodic REF, one registered command per cycle.
// Optional refresh postponement (up to 8 owed) is enabled by defining SDRAM_SCHED_REF_POSTPONE_EN.
module sdram_cmd_scheduler #(
  parameter int T_REFI = 780,
  parameter int T_RFC  = 7,
  parameter int T_RCD  = 2,
  parameter int T_AP   = 4,
  parameter int ROW_W  = 13,
  parameter int COL_W  = 9,
  parameter int BANK_W = 2
) (
  input logic                  clk,
  input logic                  rst,
  input logic                  init_done,
  sdram_cmd_scheduler_if.slave bus
);

  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_REF = 3'd5;

`ifdef SDRAM_SCHED_REF_POSTPONE_EN
  localparam int                DEBT_W   = 4;
  localparam logic [DEBT_W-1:0] DEBT_MAX = 4'd8;
`else
  localparam int                DEBT_W   = 1;
  localparam logic [DEBT_W-1:0] DEBT_MAX = 1'b1;
`endif

  localparam int REFI_W   = $clog2(T_REFI);
  localparam int WAIT_MAX = (T_RFC > T_AP) ? ((T_RFC > T_RCD) ? T_RFC : T_RCD)
                                           : ((T_AP > T_RCD) ? T_AP : T_RCD);
  localparam int WAIT_W   = $clog2(WAIT_MAX) + 1;

  typedef enum logic [2:0] {IDLE, ACT_WAIT, RW_ISSUE, AP_WAIT, REF_WAIT} state_t;

  state_t            state_q;
  logic [REFI_W-1:0] refiCnt_q, refiCnt_d;
  logic [DEBT_W-1:0] debt_q, debt_d, debtEff, debtNextEff;
  logic [WAIT_W-1:0] wait_q;
  logic              we_q;
  logic [BANK_W-1:0] bank_q, ba_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  addr_q, rwAddr;
  logic [2:0]        cmd_q;
  logic              ready_q, overrun_q;
  logic              tick, nextTick, accept, due, dueNext, refIssue, readyNext, overrunSet, waitDone;

  function automatic logic [DEBT_W-1:0] satInc(input logic [DEBT_W-1:0] d, input logic inc);
    return (inc && d != DEBT_MAX) ? d + DEBT_W'(1) : d;
  endfunction

  assign tick       = init_done && (refiCnt_q == '0);
  assign nextTick   = init_done && (refiCnt_q == REFI_W'(1));
  assign refiCnt_d  = !init_done ? refiCnt_q : (tick ? REFI_W'(T_REFI - 1) : refiCnt_q - REFI_W'(1));
  assign accept     = (state_q == IDLE) && bus.req_valid && ready_q;
  assign debtEff    = satInc(debt_q, tick);
  assign refIssue   = (state_q == IDLE) && init_done && !accept && due;
  assign overrunSet = tick && !refIssue && (debt_q == DEBT_MAX);
  assign debtNextEff = satInc(debt_d, nextTick);
  assign readyNext  = init_done && !dueNext;
  assign waitDone   = (wait_q == '0);

`ifdef SDRAM_SCHED_REF_POSTPONE_EN
  assign due     = ((debtEff != '0) && !bus.req_valid) || (debtEff == DEBT_MAX);
  assign dueNext = (debtNextEff == DEBT_MAX);
`else
  assign due     = (debtEff != '0);
  assign dueNext = (debtNextEff != '0);
`endif

  // A tick and a REF in the same cycle cancel; otherwise the debt moves by one.
  always_comb begin
    debt_d = debt_q;
    if (tick && !refIssue) begin
      debt_d = satInc(debt_q, 1'b1);
    end else if (!tick && refIssue) begin
      debt_d = debt_q - DEBT_W'(1);
    end
  end

  always_comb begin
    rwAddr            = '0;
    rwAddr[COL_W-1:0] = col_q;
    rwAddr[10]        = 1'b1;
  end

  // Exits from the wait states are decided one cycle early so that req_ready
  // and the next command land exactly on the tRCD/tAP/tRFC boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      refiCnt_q <= REFI_W'(T_REFI - 1);
      debt_q    <= '0;
      wait_q    <= '0;
      we_q      <= 1'b0;
      bank_q    <= '0;
      col_q     <= '0;
      cmd_q     <= CMD_NOP;
      ba_q      <= '0;
      addr_q    <= '0;
      ready_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      refiCnt_q <= refiCnt_d;
      debt_q    <= debt_d;
      if (overrunSet) overrun_q <= 1'b1;
      cmd_q  <= CMD_NOP;
      ba_q   <= '0;
      addr_q <= '0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q    <= bus.req_we;
            bank_q  <= bus.req_bank;
            col_q   <= bus.req_col;
            cmd_q   <= CMD_ACT;
            ba_q    <= bus.req_bank;
            addr_q  <= bus.req_row;
            wait_q  <= WAIT_W'(T_RCD - 1);
            ready_q <= 1'b0;
            state_q <= ACT_WAIT;
          end else if (refIssue) begin
            cmd_q   <= CMD_REF;
            wait_q  <= WAIT_W'(T_RFC - 2);
            ready_q <= 1'b0;
            state_q <= REF_WAIT;
          end else begin
            ready_q <= readyNext;
          end
        end
        ACT_WAIT: begin
          if (waitDone) begin
            cmd_q   <= we_q ? CMD_WR : CMD_RD;
            ba_q    <= bank_q;
            addr_q  <= rwAddr;
            wait_q  <= WAIT_W'(T_AP - 2);
            state_q <= RW_ISSUE;
          end else begin
            wait_q <= wait_q - WAIT_W'(1);
          end
        end
        RW_ISSUE, AP_WAIT, REF_WAIT: begin
          if (waitDone) begin
            ready_q <= readyNext;
            state_q <= IDLE;
          end else begin
            wait_q  <= wait_q - WAIT_W'(1);
            state_q <= (state_q == RW_ISSUE) ? AP_WAIT : state_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready   = ready_q;
  assign bus.cmd_o       = cmd_q;
  assign bus.ba_o        = ba_q;
  assign bus.addr_o      = addr_q;
  assign bus.ref_overrun = overrun_q;

endmodule

// File: tb/tb_sdram_cmd_scheduler.sv
// Scoreboard bench for sdram_cmd_scheduler: stimulus pushes expected commands,
// a monitor pops and compares each non-NOP command with its cycle.
module tb_sdram_cmd_scheduler;
  localparam int ROW_W  = 13;
  localparam int COL_W  = 9;
  localparam int BANK_W = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic initDone = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  typedef struct {
    int                cyc;
    logic [2:0]        cmd;
    logic [BANK_W-1:0] ba;
    logic [ROW_W-1:0]  addr;
  } exp_t;
  exp_t expQ[$];

  always #5 clk = ~clk;

  // Cycle index relative to the most recent reset; 0 is the first cycle after reset.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  sdram_cmd_scheduler_if #(.ROW_W(ROW_W), .COL_W(COL_W), .BANK_W(BANK_W)) busA ();
  sdram_cmd_scheduler #(.T_REFI(780), .T_RFC(7), .T_RCD(2), .T_AP(4),
                        .ROW_W(ROW_W), .COL_W(COL_W), .BANK_W(BANK_W))
    dutA (.clk(clk), .rst(rst), .init_done(initDone), .bus(busA));

`ifndef SDRAM_SCHED_REF_POSTPONE_EN
  sdram_cmd_scheduler_if #(.ROW_W(ROW_W), .COL_W(COL_W), .BANK_W(BANK_W)) busB ();
  sdram_cmd_scheduler #(.T_REFI(16), .T_RFC(7), .T_RCD(2), .T_AP(40),
                        .ROW_W(ROW_W), .COL_W(COL_W), .BANK_W(BANK_W))
    dutB (.clk(clk), .rst(rst), .init_done(initDone), .bus(busB));
`else
  sdram_cmd_scheduler_if #(.ROW_W(ROW_W), .COL_W(COL_W), .BANK_W(BANK_W)) busC ();
  sdram_cmd_scheduler #(.T_REFI(16), .T_RFC(7), .T_RCD(2), .T_AP(4),
                        .ROW_W(ROW_W), .COL_W(COL_W), .BANK_W(BANK_W))
    dutC (.clk(clk), .rst(rst), .init_done(initDone), .bus(busC));
  int refCyc[$];
`endif

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic waitCyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic valid, input logic we, input logic [BANK_W-1:0] bank,
                               input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col);
    busA.req_valid = valid;
    busA.req_we    = we;
    busA.req_bank  = bank;
    busA.req_row   = row;
    busA.req_col   = col;
  endtask

  task automatic pushExp(input int c, input logic [2:0] cmd, input logic [BANK_W-1:0] ba,
                         input logic [ROW_W-1:0] addr);
    exp_t e;
    e.cyc = c; e.cmd = cmd; e.ba = ba; e.addr = addr;
    expQ.push_back(e);
  endtask

  // Monitor: every non-NOP command must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (busA.cmd_o !== 3'd0) begin
        checks++;
        if (expQ.size() == 0) begin
          fails++;
          $display("[TB] FAIL unexpectedCmd: got cmd %0d ba %0d addr 0x%0h at cycle %0d, expected none",
                   busA.cmd_o, busA.ba_o, busA.addr_o, cyc);
        end else begin
          e = expQ.pop_front();
          if (busA.cmd_o !== e.cmd || busA.ba_o !== e.ba || busA.addr_o !== e.addr || cyc != e.cyc) begin
            fails++;
            $display("[TB] FAIL cmdMatch: got cmd %0d ba %0d addr 0x%0h cycle %0d, expected cmd %0d ba %0d addr 0x%0h cycle %0d",
                     busA.cmd_o, busA.ba_o, busA.addr_o, cyc, e.cmd, e.ba, e.addr, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Main flow on the default-parameter instance.
  initial begin
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    pushExp(780, 3'd5, 2'd0, 13'h0);
    pushExp(1560, 3'd5, 2'd0, 13'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("resetCmd", 32'(busA.cmd_o), 32'd0);
    checkOutput("resetReady", 32'(busA.req_ready), 32'd0);
    checkOutput("resetOverrun", 32'(busA.ref_overrun), 32'd0);
    waitCyc(1);
    checkOutput("readyAfterReset", 32'(busA.req_ready), 32'd1);
    waitCyc(779);
    checkOutput("readyLowBeforeRef", 32'(busA.req_ready), 32'd0);

    waitCyc(1600);
    checkOutput("readyReadAccept", 32'(busA.req_ready), 32'd1);
    applyStimulus(1'b1, 1'b0, 2'd1, 13'h123, 9'h45);
    pushExp(1601, 3'd1, 2'd1, 13'h123);
    pushExp(1603, 3'd2, 2'd1, 13'h445);
    waitCyc(1601);
    checkOutput("readyDropAfterAccept", 32'(busA.req_ready), 32'd0);
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    waitCyc(1605);
    checkOutput("readyLowInApWait", 32'(busA.req_ready), 32'd0);
    waitCyc(1606);
    checkOutput("readyEarliestNext", 32'(busA.req_ready), 32'd1);
    applyStimulus(1'b1, 1'b1, 2'd2, 13'h1abc, 9'h1ff);
    pushExp(1607, 3'd1, 2'd2, 13'h1abc);
    pushExp(1609, 3'd3, 2'd2, 13'h5ff);
    waitCyc(1607);
    applyStimulus(1'b0, 1'b0, '0, '0, '0);

`ifndef SDRAM_SCHED_REF_POSTPONE_EN
    waitCyc(2339);
    applyStimulus(1'b1, 1'b0, 2'd3, 13'h0aa, 9'h010);
    checkOutput("readyLowOnTick", 32'(busA.req_ready), 32'd0);
    pushExp(2340, 3'd5, 2'd0, 13'h0);
    pushExp(2347, 3'd1, 2'd3, 13'h0aa);
    pushExp(2349, 3'd2, 2'd3, 13'h410);
    for (int m = 2340; m <= 2345; m++) begin
      waitCyc(m);
      checkOutput("readyLowInRefWait", 32'(busA.req_ready), 32'd0);
    end
    waitCyc(2346);
    checkOutput("readyAfterRfc", 32'(busA.req_ready), 32'd1);
    waitCyc(2347);
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
`else
    pushExp(2340, 3'd5, 2'd0, 13'h0);
`endif

    waitCyc(2400);
    checkOutput("readyBeforeAbort", 32'(busA.req_ready), 32'd1);
    applyStimulus(1'b1, 1'b0, 2'd0, 13'h007, 9'h003);
    pushExp(2401, 3'd1, 2'd0, 13'h007);
    waitCyc(2401);
    applyStimulus(1'b0, 1'b0, '0, '0, '0);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("abortCmdNop", 32'(busA.cmd_o), 32'd0);
      checkOutput("abortReadyLow", 32'(busA.req_ready), 32'd0);
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);
    checkOutput("overrunA", 32'(busA.ref_overrun), 32'd0);
`ifndef SDRAM_SCHED_REF_POSTPONE_EN
    checkOutput("overrunClearedByRst", 32'(busB.ref_overrun), 32'd0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

`ifndef SDRAM_SCHED_REF_POSTPONE_EN
  // Overrun: the long tAP keeps the block busy across two interval ticks.
  initial begin
    busB.req_valid = 1'b0;
    busB.req_we    = 1'b0;
    busB.req_bank  = '0;
    busB.req_row   = 13'h001;
    busB.req_col   = 9'h001;
    waitCyc(22);
    checkOutput("overrunReadyB", 32'(busB.req_ready), 32'd1);
    busB.req_valid = 1'b1;
    waitCyc(23);
    busB.req_valid = 1'b0;
    waitCyc(30);
    checkOutput("overrunIdleB", 32'(busB.ref_overrun), 32'd0);
    waitCyc(47);
    checkOutput("overrunBeforeTick2", 32'(busB.ref_overrun), 32'd0);
    waitCyc(48);
    checkOutput("overrunSet", 32'(busB.ref_overrun), 32'd1);
    waitCyc(700);
    checkOutput("overrunSticky", 32'(busB.ref_overrun), 32'd1);
  end
`else
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && busC.cmd_o == 3'd5) refCyc.push_back(cyc);
    end
  end

  // Postpone: requests stream until debt forces a REF, then the debt drains.
  initial begin
    int drained;
    busC.req_valid = 1'b1;
    busC.req_we    = 1'b0;
    busC.req_bank  = '0;
    busC.req_row   = 13'h002;
    busC.req_col   = 9'h002;
    waitCyc(150);
    busC.req_valid = 1'b0;
    waitCyc(300);
    checkOutput("firstForcedRef", 32'(refCyc.size() > 0 ? refCyc[0] : -1), 32'd128);
    drained = 0;
    for (int i = 0; i < refCyc.size(); i++) begin
      if (refCyc[i] > 150) drained++;
      if (i > 0 && refCyc[i-1] >= 155 && refCyc[i] <= 230)
        checkOutput("drainSpacing", 32'(refCyc[i] - refCyc[i-1]), 32'd7);
    end
    checkOutput("drainCountAtLeast8", 32'(drained >= 8), 32'd1);
    checkOutput("postponeNoOverrun", 32'(busC.ref_overrun), 32'd0);
  end
`endif

endmodule
